// File: rtl/ifetch_unit_pkg.sv
// Shared RV32I fetch definitions: datapath widths, reset PC and the FIFO entry layout.
// Used by ifetch_unit and fetch_fifo.
package ifetch_unit_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // One prefetched instruction together with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    // Instructions are word aligned, so the two low address bits are forced to zero.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_fetch_fifo.sv
// Prefetch FIFO: synchronous, power-of-two depth, pointers carry one wrap bit
// so full and empty are distinguished without a separate counter.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);

    // A pop frees the slot being written, so full-with-pop may still accept a push.
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & ~i_flush & (~o_full | w_do_pop);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would make the result depend on statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; stale contents are never
    // observable because the head is masked whenever the pointers say empty.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: fetch PC, imem addressing, prefetch FIFO and redirect.
// Optional build macro IFETCH_HALT_EN stops fetching after an all-zero instruction word.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        halted
);

    logic [31:0]  r_fetch_pc;
    logic         w_pop;
    logic         w_push;
    logic         w_full;
    logic         w_empty;
    logic         w_halted;
    fetch_entry_t w_wr_entry;
    fetch_entry_t w_head;

    assign imem_addr   = r_fetch_pc;
    assign instr_valid = ~w_empty;
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.pc;
    assign halted      = w_halted;

    assign w_pop  = instr_valid & instr_ready;
    assign w_push = ~redirect_valid & ~w_halted & (~w_full | w_pop);

    assign w_wr_entry.pc    = r_fetch_pc;
    assign w_wr_entry.instr = imem_instr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_pc <= align_pc(RESET_PC);
        end else if (redirect_valid) begin
            r_fetch_pc <= align_pc(redirect_pc);
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + INSTR_BYTES;
        end
    end

`ifdef IFETCH_HALT_EN
    logic r_halted;

    // The zero word itself is still queued; only the fetches after it stop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_halted <= 1'b0;
        end else if (redirect_valid) begin
            r_halted <= 1'b0;
        end else if (w_push && (imem_instr == '0)) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halted = r_halted;
`else
    assign w_halted = 1'b0;
`endif

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fetch_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_wr_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
